// File: rtl/cnt_sched_arb.sv
// Round-robin scheduler that lends a shared divide-by-8 counter to one of two requesters
// for a requested number of wrap periods. Define CNT_SCHED_WARMUP_EN for a 2-cycle warm-up.
module cnt_sched_arb #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       i_req,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  input  logic             i_count_end,
  output logic             o_clk_en,
  output logic             o_count_valid,
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_done,
  output logic             o_busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef CNT_SCHED_WARMUP_EN
    WARMUP = 2'd1,
`endif
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_ptr;
  logic             r_idx;
  logic [LEN_W-1:0] r_remaining;
  logic             r_clk_en;
  logic             r_count_valid;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_busy;
`ifdef CNT_SCHED_WARMUP_EN
  logic             r_warm_cnt;
`endif

  logic             w_win;
  logic [LEN_W-1:0] w_len;
  logic             w_abort;

  // Contention goes to the pointer; a lone requester always wins.
  assign w_win   = (i_req == 2'b11) ? r_ptr : i_req[1];
  assign w_len   = w_win ? i_len1 : i_len0;
  assign w_abort = ~i_req[r_idx];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_ptr         <= 1'b0;
      r_idx         <= 1'b0;
      r_remaining   <= '0;
      r_clk_en      <= 1'b0;
      r_count_valid <= 1'b0;
      r_gnt         <= 2'b00;
      r_done        <= 2'b00;
      r_busy        <= 1'b0;
`ifdef CNT_SCHED_WARMUP_EN
      r_warm_cnt    <= 1'b0;
`endif
    end else begin
      r_done <= 2'b00;
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_idx       <= w_win;
            r_gnt       <= w_win ? 2'b10 : 2'b01;
            r_remaining <= w_len;
            r_busy      <= 1'b1;
            if (w_len == '0) begin
              r_state <= DONE;
              r_done  <= w_win ? 2'b10 : 2'b01;
            end else begin
`ifdef CNT_SCHED_WARMUP_EN
              r_state    <= WARMUP;
              r_warm_cnt <= 1'b0;
              r_clk_en   <= 1'b1;
`else
              r_state       <= RUN;
              r_clk_en      <= 1'b1;
              r_count_valid <= 1'b1;
`endif
            end
          end
        end
`ifdef CNT_SCHED_WARMUP_EN
        WARMUP: begin
          if (w_abort) begin
            r_state       <= IDLE;
            r_ptr         <= ~r_idx;
            r_gnt         <= 2'b00;
            r_clk_en      <= 1'b0;
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
          end else if (r_warm_cnt) begin
            r_state       <= RUN;
            r_count_valid <= 1'b1;
          end else begin
            r_warm_cnt <= 1'b1;
          end
        end
`endif
        RUN: begin
          // Abort wins over a coincident wrap pulse.
          if (w_abort) begin
            r_state       <= IDLE;
            r_ptr         <= ~r_idx;
            r_gnt         <= 2'b00;
            r_clk_en      <= 1'b0;
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
          end else if (i_count_end) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state       <= DONE;
              r_done        <= r_gnt;
              r_clk_en      <= 1'b0;
              r_count_valid <= 1'b0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ptr   <= ~r_idx;
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clk_en      = r_clk_en;
  assign o_count_valid = r_count_valid;
  assign o_gnt         = r_gnt;
  assign o_done        = r_done;
  assign o_busy        = r_busy;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cnt_sched_arb.sv
// Directed bench for cnt_sched_arb: a cycle-by-cycle vector table plus hand sequences
// for the multi-cycle cases. Build with CNT_SCHED_WARMUP_EN to exercise the warm-up path.
module tb_cnt_sched_arb;

  localparam int LEN_W = 4;

  // Expected output word: {gnt[1:0], done[1:0], clk_en, count_valid, busy}
  localparam logic [6:0] O_IDLE = 7'b00_00_000;
  localparam logic [6:0] O_RUN0 = 7'b01_00_111;
  localparam logic [6:0] O_RUN1 = 7'b10_00_111;
  localparam logic [6:0] O_DN0  = 7'b01_01_001;
  localparam logic [6:0] O_DN1  = 7'b10_10_001;
  localparam logic [6:0] O_WU0  = 7'b01_00_101;

  logic             clk;
  logic             resetn;
  logic [1:0]       i_req;
  logic [LEN_W-1:0] i_len0;
  logic [LEN_W-1:0] i_len1;
  logic             i_count_end;
  logic             o_clk_en;
  logic             o_count_valid;
  logic [1:0]       o_gnt;
  logic [1:0]       o_done;
  logic             o_busy;
  logic [1:0]       o_dbg_state;

  int total;
  int bad;
  logic [6:0] exp_q[$];

  typedef struct {
    logic             rstn;
    logic [1:0]       req;
    logic [LEN_W-1:0] l0;
    logic [LEN_W-1:0] l1;
    logic             ce;
    logic [6:0]       exp;
    string            name;
  } vec_t;

  vec_t tbl[$];

  cnt_sched_arb #(.LEN_W(LEN_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_req         (i_req),
    .i_len0        (i_len0),
    .i_len1        (i_len1),
    .i_count_end   (i_count_end),
    .o_clk_en      (o_clk_en),
    .o_count_valid (o_count_valid),
    .o_gnt         (o_gnt),
    .o_done        (o_done),
    .o_busy        (o_busy),
    .o_dbg_state   (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rstn, input logic [1:0] req,
                              input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1,
                              input logic ce, input logic [6:0] exp, input string name);
    vec_t v;
    v.rstn = rstn; v.req = req; v.l0 = l0; v.l1 = l1; v.ce = ce; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  // driver: present inputs for one edge, then check outputs 1 time unit after it
  task automatic apply(input logic rstn, input logic [1:0] req,
                       input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1,
                       input logic ce, input logic [6:0] exp, input string name);
    logic [6:0] act;
    logic [6:0] want;
    resetn      = rstn;
    i_req       = req;
    i_len0      = l0;
    i_len1      = l1;
    i_count_end = ce;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    act  = {o_gnt, o_done, o_clk_en, o_count_valid, o_busy};
    want = exp_q.pop_front();
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got gnt/done/clk_en/valid/busy=%b required %b", name, act, want);
    end
  endtask

  initial begin
    int pulses;
    logic [6:0] e;
    total = 0;
    bad = 0;
    resetn = 1'b0; i_req = 2'b00; i_len0 = '0; i_len1 = '0; i_count_end = 1'b0;
    @(posedge clk);
    #1;

`ifndef CNT_SCHED_WARMUP_EN
    add(0, 2'b00, 0, 0, 0, O_IDLE, "reset");
    add(1, 2'b10, 0, 0, 0, O_DN1,  "len0_done");
    add(1, 2'b00, 0, 0, 1, O_IDLE, "len0_idle");
    add(0, 2'b00, 0, 0, 0, O_IDLE, "reset2");
    add(1, 2'b11, 1, 1, 0, O_RUN0, "rr_g0_run");
    add(1, 2'b11, 1, 1, 1, O_DN0,  "rr_g0_done");
    add(1, 2'b11, 1, 1, 0, O_IDLE, "rr_g0_idle");
    add(1, 2'b11, 1, 1, 0, O_RUN1, "rr_g1_run");
    add(1, 2'b11, 1, 1, 1, O_DN1,  "rr_g1_done");
    add(1, 2'b11, 1, 1, 1, O_IDLE, "rr_g1_idle");
    add(1, 2'b11, 1, 1, 0, O_RUN0, "rr_g2_run");
    add(1, 2'b11, 1, 1, 1, O_DN0,  "rr_g2_done");
    add(1, 2'b00, 1, 1, 0, O_IDLE, "rr_idle");
    add(1, 2'b00, 1, 1, 1, O_IDLE, "ce_in_idle");
    add(1, 2'b01, 4, 0, 0, O_RUN0, "pre_rst_run");
    add(0, 2'b01, 4, 0, 0, O_IDLE, "rst_mid_run");
    add(1, 2'b11, 4, 4, 0, O_RUN0, "ptr_after_rst");
    add(1, 2'b00, 4, 4, 0, O_IDLE, "abort_run");
    add(1, 2'b10, 0, 2, 0, O_RUN1, "len_latch_run");
    add(1, 2'b10, 0, 0, 1, O_RUN1, "len_chg_a");
    add(1, 2'b10, 0, 7, 0, O_RUN1, "len_chg_b");
    add(1, 2'b10, 0, 7, 1, O_DN1,  "len_latch_done");
    add(1, 2'b00, 0, 0, 0, O_IDLE, "len_latch_idle");
    foreach (tbl[i])
      apply(tbl[i].rstn, tbl[i].req, tbl[i].l0, tbl[i].l1, tbl[i].ce, tbl[i].exp, tbl[i].name);

    // wrap pulse every 8 cycles, length 3
    apply(0, 2'b00, 0, 0, 0, O_IDLE, "seq29_reset");
    apply(1, 2'b01, 3, 0, 0, O_RUN0, "seq29_grant");
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      if (c % 8 == 7) pulses++;
      e = (pulses == 3) ? O_DN0 : O_RUN0;
      apply(1, 2'b01, 3, 0, logic'(c % 8 == 7), e, "seq29_count");
    end
    apply(1, 2'b00, 3, 0, 0, O_IDLE, "seq29_idle");

    // abort coinciding with the 3rd wrap pulse
    apply(0, 2'b00, 0, 0, 0, O_IDLE, "seq32_reset");
    apply(1, 2'b01, 5, 0, 0, O_RUN0, "seq32_grant");
    apply(1, 2'b01, 5, 0, 1, O_RUN0, "seq32_p1");
    apply(1, 2'b01, 5, 0, 0, O_RUN0, "seq32_gap");
    apply(1, 2'b01, 5, 0, 1, O_RUN0, "seq32_p2");
    apply(1, 2'b00, 5, 0, 1, O_IDLE, "seq32_abort");
    apply(1, 2'b11, 5, 5, 0, O_RUN1, "seq32_ptr");
    apply(1, 2'b00, 5, 5, 0, O_IDLE, "seq32_end");
`else
    apply(0, 2'b00, 0, 0, 0, O_IDLE, "wu_reset");
    apply(1, 2'b01, 2, 0, 0, O_WU0,  "wu_cycle1");
    apply(1, 2'b01, 2, 0, 1, O_WU0,  "wu_cycle2");
    apply(1, 2'b01, 2, 0, 0, O_RUN0, "wu_run");
    apply(1, 2'b01, 2, 0, 1, O_RUN0, "wu_p1");
    apply(1, 2'b01, 2, 0, 1, O_DN0,  "wu_done");
    apply(1, 2'b11, 2, 2, 0, O_IDLE, "wu_idle");
    apply(1, 2'b11, 2, 2, 0, 7'b10_00_101, "wu_rr_g1");
    apply(1, 2'b01, 2, 2, 0, O_IDLE, "wu_abort");
    apply(1, 2'b00, 2, 2, 0, O_IDLE, "wu_end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
